// File: rtl/btn_conditioner.sv
// Button/switch input conditioning: 2-flop synchronisers, per-channel debounce and press strobes.
// Optional auto-repeat on held buttons is built when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
  parameter int NUM_BTNS        = 4,
  parameter int NUM_SWS         = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btns_raw,
  input  logic [NUM_SWS-1:0]  swtchs_raw,
  output logic [NUM_BTNS-1:0] btns_level,
  output logic [NUM_BTNS-1:0] btns_pulse,
  output logic [NUM_SWS-1:0]  swtchs_sync
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY ||
      (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W)) begin : g_param_check
    $error("btn_conditioner: illegal parameter set");
  end

  logic [NUM_BTNS-1:0] btn_meta;
  logic [NUM_BTNS-1:0] btn_sync;
  logic [NUM_SWS-1:0]  sw_meta;
  logic [CNT_W-1:0]    cnt [NUM_BTNS];
  logic [NUM_BTNS-1:0] accept;
  logic [NUM_BTNS-1:0] press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta    <= '0;
      btn_sync    <= '0;
      sw_meta     <= '0;
      swtchs_sync <= '0;
    end else begin
      btn_meta    <= btns_raw;
      btn_sync    <= btn_meta;
      sw_meta     <= swtchs_raw;
      swtchs_sync <= sw_meta;
    end
  end

  // accept: the synchronised bit has disagreed with the level for a full debounce window.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      accept[i] = (btn_sync[i] != btns_level[i]) && (cnt[i] == CNT_MAX);
    end
  end

  assign press = accept & btn_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btns_level <= '0;
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        if (btn_sync[i] == btns_level[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i]        <= '0;
          btns_level[i] <= btn_sync[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int             RPT_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0]    rpt [NUM_BTNS];
  logic [NUM_BTNS-1:0] rpt_fire;

  // Pulse fires on the edge the timer would reach REPEAT_DELAY; reloading to
  // DELAY-PERIOD then spaces later pulses REPEAT_PERIOD apart. A level that is
  // falling this cycle (level high and accept) neither fires nor keeps counting.
  always_comb begin
    rpt_fire = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      rpt_fire[i] = btns_level[i] && !accept[i] && (rpt[i] == RPT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        rpt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        if (!btns_level[i] || accept[i]) begin
          rpt[i] <= '0;
        end else if (rpt_fire[i]) begin
          rpt[i] <= RPT_RELOAD;
        end else begin
          rpt[i] <= rpt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btns_pulse <= '0;
    end else begin
      btns_pulse <= press | rpt_fire;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btns_pulse <= '0;
    end else begin
      btns_pulse <= press;
    end
  end
`endif

endmodule
